alu_v_seq: RTL and testbench
============================

Name: alu_v_seq

Overview:
- Parametrised, registered successor to the combinational RISC-V ALU top (ALU control decode plus datapath).
- Decodes ALUOp/FuncCode internally and executes RV32I/RV64I integer ops in one cycle.
- With ENABLE_M=1, also executes RV M-extension ops (MUL/MULH*/DIV*/REM*) iteratively in WIDTH+1 cycles.
- Valid/ready handshake on both sides; sits between ID/EX operand latches and EX/MEM in the multi-cycle core.

Parameters:
WIDTH, 32, datapath width; power of two, 8..64; shift amount = B[log2(WIDTH)-1:0]
ENABLE_M, 1, 1 = decode funct7=0000001 as M ops; 0 = those encodings are illegal

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock, one synchronous active-high reset
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept this cycle
ALUOp  input  2  00 add, 01 sub, 10 R-type decode, 11 I-type decode
FuncCode  input  10  {funct3[9:7], funct7[6:0]}
A  input  WIDTH  operand 1 (rs1)
B  input  WIDTH  operand 2 (rs2/imm)
out_valid  output  1  result registers valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  result == 0
overflow  output  1  signed overflow, ADD/SUB only; else 0
cout  output  1  carry out of ADD; for SUB, 1 = no borrow (A >= B unsigned); else 0
illegal  output  1  undecodable op

Behaviour:
- Reset: state IDLE, out_valid=0, result=0, zero=0, overflow=0, cout=0, illegal=0, counter=0. Reset mid-iteration aborts the op silently; nothing is emitted.
- Accept: in_valid & in_ready at a rising edge. in_ready = (state==IDLE) & (!out_valid | out_ready).
- Back-pressure: out_valid/result/flags hold stable while out_valid & !out_ready. Output drops when out_ready is high and no new result loads the same edge.
- Decode, ALUOp 00: ADD.
- Decode, ALUOp 01: SUB.
- Decode, ALUOp 10 (R-type):
  - funct7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: f3 000 SUB, 101 SRA.
  - funct7=0000001 (ENABLE_M): f3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Anything else is illegal.
- Decode, ALUOp 11 (I-type): f3 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI, 001 SLLI. f3 101: SRAI if funct7[5]=1, else SRLI. Other funct7 bits are ignored.
- Single-cycle ops (incl. illegal): result registered at the accept edge; out_valid=1 after that edge (latency 1). Illegal gives result=0, illegal=1, flags 0.
- States: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL/DIV on accepting an M op. Capture |A| and |B| per signedness, record result sign, counter=WIDTH.
  - MUL: radix-2 shift-add, 2*WIDTH-bit product, one bit per edge.
  - DIV: restoring division, one quotient bit per edge.
  - Counter decrements each edge; at 0 go to FIX.
  - FIX: apply sign correction, select low/high half or quotient/remainder, load output, out_valid=1, go to IDLE.
  - Total: out_valid rises WIDTH+1 edges after the accept edge.
- MUL returns low WIDTH bits. MULH is signed x signed, MULHSU is signed A x unsigned B, MULHU is unsigned; all return high WIDTH bits.
- DIV/REM round toward zero; remainder takes the dividend's sign.
- Divide by zero: DIV/DIVU = all-ones, REM/REMU = A.
- Signed overflow (A = most-negative, B = -1): DIV = A, REM = 0.
- zero is computed from the final result for every op. overflow/cout are 0 for all ops except ADD/ADDI/SUB.
- SUB overflow = (A[msb] != B[msb]) & (res[msb] != A[msb]).
- in_ready stays low during MUL/DIV/FIX. in_valid during busy cycles is ignored, not queued.

Test Plan:
- Back-to-back ADD: A=32'h7FFFFFFF, B=1, ALUOp=00, out_ready=1 -> result 32'h80000000, overflow=1, cout=0. Next op SUB 5-5 issued the following cycle -> result 0, zero=1, cout=1; one result per cycle.
- R-type SRA: A=32'hF0000000, B=36, FuncCode={101,0100000} -> result 32'hFF000000 (shamt 4). Same operands as SRAI via ALUOp=11 give the same result.
- MULH: A=-2, B=3, FuncCode={001,0000001} -> out_valid exactly 33 edges after accept, result 32'hFFFFFFFF. MUL on the same operands -> 32'hFFFFFFFA. in_ready=0 throughout.
- Division corners:
  - DIV 32'h80000000 / -1 -> 32'h80000000.
  - REM of the same -> 0.
  - DIVU 7/0 -> 32'hFFFFFFFF.
  - REMU 7/0 -> 7.
  - DIV -7/2 -> -3; REM -7/2 -> -1.
- Back-pressure/reset: out_ready=0 for 5 cycles after AND result -> result stable, in_ready=0. Separately, reset asserted mid-DIV at iteration 10 -> out_valid never rises, in_ready=1 the next cycle.
- Illegal and ENABLE_M=0: FuncCode={000,0000001} with ENABLE_M=0 -> illegal=1, result 0, latency 1. R-type funct7=0100000, f3=001 -> illegal=1.

Source files
------------

// File: rtl/alu_v_seq.sv
// alu_v_seq: registered RISC-V integer ALU with ALU-control decode.
// Single-cycle RV32I/RV64I ops; optional iterative M-extension
// (shift-add multiply, restoring divide) taking WIDTH+1 cycles.
// Valid/ready handshake on input and output.
module alu_v_seq #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ENABLE_M = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [9:0]       FuncCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             cout,
  output logic             illegal
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } op_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  op_t                  mop_q, mop_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 overflow_q, overflow_d;
  logic                 cout_q, cout_d;
  logic                 illegal_q, illegal_d;

  logic [2:0]           f3;
  logic [6:0]           f7;
  op_t                  dec_op;
  logic                 dec_is_m;
  logic                 dec_is_div;
  logic                 accept;

  assign f3 = FuncCode[9:7];
  assign f7 = FuncCode[6:0];

  assign in_ready  = (state_q == S_IDLE) & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign cout      = cout_q;
  assign illegal   = illegal_q;

  // ALU control: map ALUOp/funct3/funct7 to an operation
  always_comb begin
    dec_op = OP_ILL;
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      dec_op = OP_SUB;
          else if (f3 == 3'b101) dec_op = OP_SRA;
        end else if ((f7 == 7'b0000001) && (ENABLE_M != 0)) begin
          case (f3)
            3'b000:  dec_op = OP_MUL;
            3'b001:  dec_op = OP_MULH;
            3'b010:  dec_op = OP_MULHSU;
            3'b011:  dec_op = OP_MULHU;
            3'b100:  dec_op = OP_DIV;
            3'b101:  dec_op = OP_DIVU;
            3'b110:  dec_op = OP_REM;
            default: dec_op = OP_REMU;
          endcase
        end
      end
      default: begin
        case (f3)
          3'b000:  dec_op = OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = f7[5] ? OP_SRA : OP_SRL;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
    endcase
  end

  assign dec_is_m   = dec_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                     OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign dec_is_div = dec_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             sc_cout;

  assign shamt    = B[SW-1:0];
  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} - {1'b0, B};

  // Single-cycle datapath and ADD/SUB flags
  always_comb begin
    sc_res  = '0;
    sc_ovf  = 1'b0;
    sc_cout = 1'b0;
    case (dec_op)
      OP_ADD: begin
        sc_res  = add_full[WIDTH-1:0];
        sc_cout = add_full[WIDTH];
        sc_ovf  = (A[WIDTH-1] == B[WIDTH-1]) & (add_full[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res  = sub_full[WIDTH-1:0];
        sc_cout = ~sub_full[WIDTH];
        sc_ovf  = (A[WIDTH-1] != B[WIDTH-1]) & (sub_full[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:  sc_res = A << shamt;
      OP_SRL:  sc_res = A >> shamt;
      OP_SRA:  sc_res = $signed(A) >>> shamt;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_XOR:  sc_res = A ^ B;
      OP_OR:   sc_res = A | B;
      OP_AND:  sc_res = A & B;
      default: sc_res = '0;
    endcase
  end

  logic             sgn_a, sgn_b;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             setup_neg;

  // Operand signedness and magnitudes captured when an M op is accepted
  always_comb begin
    sgn_a     = dec_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    sgn_b     = dec_op inside {OP_MULH, OP_DIV, OP_REM};
    a_neg     = sgn_a & A[WIDTH-1];
    b_neg     = sgn_b & B[WIDTH-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
    setup_neg = a_neg ^ b_neg;
    // Quotient keeps a positive sign on divide-by-zero so DIV gives all-ones;
    // the remainder follows the dividend, which makes REM by zero return A.
    if (dec_op == OP_DIV)      setup_neg = (a_neg ^ b_neg) & (B != '0);
    else if (dec_op == OP_REM) setup_neg = a_neg;
  end

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_rsh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  // prod_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  assign mul_sum  = prod_q[0] ? ({1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q})
                              : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  assign div_rsh  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_ge   = div_rsh >= {1'b0, mcand_q};
  assign div_rem  = div_ge ? (div_rsh[WIDTH-1:0] - mcand_q) : div_rsh[WIDTH-1:0];
  assign div_next = {div_rem, prod_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] mul_signed;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fix_res;

  assign mul_signed = neg_q ? -prod_q : prod_q;
  assign quo        = prod_q[WIDTH-1:0];
  assign rem        = prod_q[2*WIDTH-1:WIDTH];

  // Sign correction and half/quotient/remainder selection in FIX
  always_comb begin
    case (mop_q)
      OP_MUL:                        fix_res = mul_signed[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = mul_signed[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               fix_res = neg_q ? -quo : quo;
      OP_REM, OP_REMU:               fix_res = neg_q ? -rem : rem;
      default:                       fix_res = '0;
    endcase
  end

  // Next-state: sequencer, iteration registers and output registers
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mop_d       = mop_q;
    neg_d       = neg_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    cout_d      = cout_q;
    illegal_d   = illegal_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (dec_is_m) begin
            state_d = dec_is_div ? S_DIV : S_MUL;
            cnt_d   = CW'(WIDTH);
            mop_d   = dec_op;
            neg_d   = setup_neg;
            if (dec_is_div) begin
              prod_d  = {{WIDTH{1'b0}}, a_mag};
              mcand_d = b_mag;
            end else begin
              prod_d  = {{WIDTH{1'b0}}, b_mag};
              mcand_d = a_mag;
            end
          end else begin
            out_valid_d = 1'b1;
            result_d    = sc_res;
            zero_d      = (sc_res == '0);
            overflow_d  = sc_ovf;
            cout_d      = sc_cout;
            illegal_d   = (dec_op == OP_ILL);
          end
        end
      end
      S_MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_DIV: begin
        prod_d = div_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      default: begin
        out_valid_d = 1'b1;
        result_d    = fix_res;
        zero_d      = (fix_res == '0);
        overflow_d  = 1'b0;
        cout_d      = 1'b0;
        illegal_d   = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mop_q       <= OP_ADD;
      neg_q       <= 1'b0;
      prod_q      <= '0;
      mcand_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      cout_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mop_q       <= mop_d;
      neg_q       <= neg_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      cout_q      <= cout_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_v_seq.sv
// Testbench for alu_v_seq: directed vectors with literal expectations plus
// a per-cycle comparison against a spec-level behavioural model.
module tb_alu_v_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  ALUOp = 2'b00;
  logic [9:0]  FuncCode = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero, overflow, cout, illegal;

  logic        nm_in_valid = 1'b0;
  logic        nm_in_ready;
  logic [1:0]  nm_ALUOp = 2'b10;
  logic [9:0]  nm_FuncCode = '0;
  logic [31:0] nm_A = '0;
  logic [31:0] nm_B = '0;
  logic        nm_out_valid;
  logic [31:0] nm_result;
  logic        nm_zero, nm_overflow, nm_cout, nm_illegal;

  alu_v_seq #(.WIDTH(32), .ENABLE_M(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .FuncCode(FuncCode), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .cout(cout), .illegal(illegal)
  );

  alu_v_seq #(.WIDTH(32), .ENABLE_M(0)) dut_nm (
    .clk(clk), .reset(reset), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .ALUOp(nm_ALUOp), .FuncCode(nm_FuncCode), .A(nm_A), .B(nm_B),
    .out_valid(nm_out_valid), .out_ready(1'b1), .result(nm_result),
    .zero(nm_zero), .overflow(nm_overflow), .cout(nm_cout), .illegal(nm_illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] res;
    logic        z, o, c, i;
    int          extra;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
    end
  endtask

  // Spec-level model: decode to an op name, compute with 64-bit arithmetic.
  function automatic exp_t model(logic [1:0] op, logic [9:0] fc,
                                 logic [31:0] a, logic [31:0] b, bit em);
    exp_t        e;
    logic [2:0]  f3 = fc[9:7];
    logic [6:0]  f7 = fc[6:0];
    string       k  = "ILL";
    longint      sa = $signed(a);
    longint      sbv = $signed(b);
    longint      ua = {32'h0, a};
    longint      ub = {32'h0, b};
    longint      p;
    longint      t;
    string       rt [8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
    string       mt [8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};
    e.res = '0; e.z = 0; e.o = 0; e.c = 0; e.i = 0; e.extra = 0; e.due = 0;
    case (op)
      2'd0: k = "ADD";
      2'd1: k = "SUB";
      2'd2: begin
        if (f7 == 7'h00) k = rt[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) k = "SUB";
        else if (f7 == 7'h20 && f3 == 3'd5) k = "SRA";
        else if (f7 == 7'h01 && em) k = mt[f3];
      end
      default: begin
        k = rt[f3];
        if (f3 == 3'd5 && f7[5]) k = "SRA";
      end
    endcase
    case (k)
      "ADD":    begin p = ua + ub; e.res = p[31:0]; e.c = p[32];
                  t = $signed(e.res); e.o = (sa + sbv) != t; end
      "SUB":    begin e.res = a - b; e.c = (a >= b);
                  t = $signed(e.res); e.o = (sa - sbv) != t; end
      "SLL":    e.res = a << b[4:0];
      "SRL":    e.res = a >> b[4:0];
      "SRA":    begin p = sa >>> b[4:0]; e.res = p[31:0]; end
      "SLT":    e.res = (sa < sbv) ? 32'd1 : 32'd0;
      "SLTU":   e.res = (a < b) ? 32'd1 : 32'd0;
      "XOR":    e.res = a ^ b;
      "OR":     e.res = a | b;
      "AND":    e.res = a & b;
      "MUL":    begin p = sa * sbv; e.res = p[31:0]; end
      "MULH":   begin p = sa * sbv; e.res = p[63:32]; end
      "MULHSU": begin p = sa * ub;  e.res = p[63:32]; end
      "MULHU":  begin p = ua * ub;  e.res = p[63:32]; end
      "DIV":    begin if (b == 0) e.res = '1; else begin p = sa / sbv; e.res = p[31:0]; end end
      "REM":    begin if (b == 0) e.res = a;  else begin p = sa % sbv; e.res = p[31:0]; end end
      "DIVU":   begin if (b == 0) e.res = '1; else begin p = ua / ub;  e.res = p[31:0]; end end
      "REMU":   begin if (b == 0) e.res = a;  else begin p = ua % ub;  e.res = p[31:0]; end end
      default:  e.i = 1'b1;
    endcase
    if (k inside {"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"}) e.extra = 33;
    e.z = (e.res == 0);
    return e;
  endfunction

  // Per-cycle compare against the model: valid, ready and output contents
  bit m_ov, m_busy, m_rdy;
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      m_ov   = (sb.size() > 0) && (cycle >= sb[0].due);
      m_busy = (sb.size() > 0) && (sb[0].extra > 0) && (cycle < sb[0].due);
      m_rdy  = !m_busy && (!m_ov || out_ready);
      chk("m_out_valid", out_valid, m_ov);
      chk("m_in_ready", in_ready, m_rdy);
      if (m_ov) begin
        chk("m_result", result, sb[0].res);
        chk("m_zero", zero, sb[0].z);
        chk("m_overflow", overflow, sb[0].o);
        chk("m_cout", cout, sb[0].c);
        chk("m_illegal", illegal, sb[0].i);
        if (out_ready) void'(sb.pop_front());
      end
      if (in_valid && m_rdy) begin
        exp_t e;
        e = model(ALUOp, FuncCode, A, B, 1'b1);
        e.due = cycle + 1 + e.extra;
        sb.push_back(e);
      end
    end
  end

  task automatic issue(logic [1:0] op, logic [9:0] fc, logic [31:0] a, logic [31:0] b);
    int n = 0;
    ALUOp = op; FuncCode = fc; A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout got=0 want=1");
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic expect_out(string nm, logic [31:0] r, logic z, logic o, logic c,
                            logic i, int lat);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_res"}, result, r);
    chk({nm, "_zero"}, zero, z);
    chk({nm, "_ovf"}, overflow, o);
    chk({nm, "_cout"}, cout, c);
    chk({nm, "_ill"}, illegal, i);
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [9:0]  fc;
    logic [31:0] a, b, r;
    logic        z, o, c, i;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic addv(string nm, logic [1:0] op, logic [9:0] fc, logic [31:0] a,
                      logic [31:0] b, logic [31:0] r, logic z, logic o, logic c,
                      logic i, int lat);
    vec_t v;
    v.nm = nm; v.op = op; v.fc = fc; v.a = a; v.b = b; v.r = r;
    v.z = z; v.o = o; v.c = c; v.i = i; v.lat = lat;
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //    name        op     fc      A             B             result        z o c i lat
    addv("add_wrap", 2'd0, 10'h000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 0, 0);
    addv("sub_ovf",  2'd1, 10'h000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1, 0, 0);
    addv("sub_brw",  2'd1, 10'h000, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0, 0, 0);
    addv("sll",      2'd2, 10'h080, 32'h00000001, 32'h00000021, 32'h00000002, 0, 0, 0, 0, 0);
    addv("slt",      2'd2, 10'h100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 0);
    addv("sltu",     2'd2, 10'h180, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 0, 0, 0);
    addv("xor",      2'd2, 10'h200, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 0, 0);
    addv("srl",      2'd2, 10'h280, 32'hF0000000, 32'h00000004, 32'h0F000000, 0, 0, 0, 0, 0);
    addv("or",       2'd2, 10'h300, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    addv("sra",      2'd2, 10'h2A0, 32'hF0000000, 32'd36,       32'hFF000000, 0, 0, 0, 0, 0);
    addv("srai",     2'd3, 10'h2A0, 32'hF0000000, 32'd36,       32'hFF000000, 0, 0, 0, 0, 0);
    addv("srli",     2'd3, 10'h280, 32'hF0000000, 32'd36,       32'h0F000000, 0, 0, 0, 0, 0);
    addv("addi_f7",  2'd3, 10'h07F, 32'h0000000A, 32'hFFFFFFFF, 32'h00000009, 0, 0, 1, 0, 0);
    addv("slti",     2'd3, 10'h100, 32'h00000005, 32'hFFFFFFFB, 32'h00000000, 1, 0, 0, 0, 0);
    addv("ill_sub1", 2'd2, 10'h0A0, 32'h00000005, 32'h00000003, 32'h00000000, 1, 0, 0, 1, 0);
    addv("ill_f7",   2'd2, 10'h002, 32'h00000005, 32'h00000003, 32'h00000000, 1, 0, 0, 1, 0);
    addv("mulh",     2'd2, 10'h081, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 0, 0, 0, 0, 33);
    addv("mul",      2'd2, 10'h001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 0, 0, 0, 0, 33);
    addv("mulhsu",   2'd2, 10'h101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 33);
    addv("mulhu",    2'd2, 10'h181, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 0, 33);
    addv("div_ovf",  2'd2, 10'h201, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0, 0, 33);
    addv("rem_ovf",  2'd2, 10'h301, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 0, 33);
    addv("divu_z",   2'd2, 10'h281, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0, 33);
    addv("remu_z",   2'd2, 10'h381, 32'h00000007, 32'h00000000, 32'h00000007, 0, 0, 0, 0, 33);
    addv("div_neg",  2'd2, 10'h201, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0, 0, 0, 0, 33);
    addv("rem_neg",  2'd2, 10'h301, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 0, 0, 0, 0, 33);
    addv("div_z",    2'd2, 10'h201, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0, 33);
    addv("rem_z",    2'd2, 10'h301, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 0, 0, 0, 0, 33);
    addv("divu",     2'd2, 10'h281, 32'd100,      32'd7,        32'd14,       0, 0, 0, 0, 33);
    addv("remu",     2'd2, 10'h381, 32'd100,      32'd7,        32'd2,        0, 0, 0, 0, 33);

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cout", cout, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Back-to-back ADD then SUB, one result per cycle
    ALUOp = 2'd0; FuncCode = '0; A = 32'h7FFFFFFF; B = 32'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    ALUOp = 2'd1; A = 32'd5; B = 32'd5;
    @(negedge clk);
    chk("b2b_add_valid", out_valid, 1);
    chk("b2b_add_res", result, 32'h80000000);
    chk("b2b_add_ovf", overflow, 1);
    chk("b2b_add_cout", cout, 0);
    chk("b2b_add_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_sub_valid", out_valid, 1);
    chk("b2b_sub_res", result, 32'h0);
    chk("b2b_sub_zero", zero, 1);
    chk("b2b_sub_cout", cout, 1);
    @(posedge clk); #1;

    // Directed vector table
    foreach (vt[j]) begin
      issue(vt[j].op, vt[j].fc, vt[j].a, vt[j].b);
      expect_out(vt[j].nm, vt[j].r, vt[j].z, vt[j].o, vt[j].c, vt[j].i, vt[j].lat);
    end

    // Back-pressure: AND result held while out_ready is low; new input ignored
    out_ready = 1'b0;
    issue(2'd2, 10'h380, 32'hF0F0F0F0, 32'hFF00FF00);
    ALUOp = 2'd0; FuncCode = '0; A = 32'd1; B = 32'd1; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 32'hF000F000);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_res", result, 32'hF000F000);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_res", result, 32'd2);
    @(posedge clk); #1;

    // Reset in the middle of a DIV aborts it silently
    begin
      bit seen = 1'b0;
      issue(2'd2, 10'h201, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", in_ready, 1);
      repeat (40) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("abort_no_valid", seen, 0);
      @(posedge clk); #1;
    end

    // ENABLE_M=0: M encodings are illegal, latency 1
    nm_ALUOp = 2'd2; nm_FuncCode = 10'h001; nm_A = 32'd5; nm_B = 32'd3; nm_in_valid = 1'b1;
    @(negedge clk);
    chk("nm_in_ready", nm_in_ready, 1);
    @(posedge clk); #1 nm_in_valid = 1'b0;
    @(negedge clk);
    chk("nm_valid", nm_out_valid, 1);
    chk("nm_ill", nm_illegal, 1);
    chk("nm_res", nm_result, 0);
    chk("nm_ovf", nm_overflow, 0);
    @(posedge clk); #1;
    nm_FuncCode = 10'h000; nm_in_valid = 1'b1;
    @(posedge clk); #1 nm_in_valid = 1'b0;
    @(negedge clk);
    chk("nm_add_ill", nm_illegal, 0);
    chk("nm_add_res", nm_result, 32'd8);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
